nonce_scanner: RTL and testbench
================================

# nonce_scanner

Mining sequencer that drives the double-SHA256 hash core as its initiator. It holds a 76-byte header template, sweeps the 32-bit nonce over a programmed range, and issues one core transaction per nonce. It checks each digest against a 256-bit target and reports the first nonce whose hash meets it. It sits between the host register interface and the hash core.

## Interface
- `WATCHDOG`, default 511: maximum cycles allowed between `core_start` and `core_done`; must be ≥ 300.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `load`  in  1  pulse; captures `header_in`, `target`, `nonce_start` and `nonce_end`. Ignored while `busy`.
- `header_in`  in  608  version..nbits, serialized byte order; MSB is the first byte.
- `target`  in  256  numeric target; a hash meets it when hash ≤ target.
- `nonce_start`, `nonce_end`  in  32 each  inclusive numeric range.
- `start`  in  1  pulse; begins a scan. Ignored while `busy`.
- `abort`  in  1  level; stops the scan.
- `core_rst_n`  out  1  re-arm for the hash core (the core is single-shot).
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_block`  out  640  `{header_q, bswap32(cur_nonce)}`.
- `core_hash`  in  256  digest in core byte order.
- `core_done`  in  1  core completion; sticky until `core_rst_n` goes low.
- `busy`  out  1  scan in progress.
- `found`  out  1  level; a hit occurred.
- `found_nonce`  out  32  nonce of the hit.
- `found_hash`  out  256  byte-reversed digest (display order) of the hit.
- `exhausted`  out  1  range completed with no hit.
- `timeout`  out  1  the watchdog expired.
- `cur_nonce`  out  32  nonce currently being hashed.

## Operation
- Reset values:
  - `core_rst_n`, `core_start`, `busy`, `found`, `exhausted`, `timeout`: 0.
  - `found_nonce`, `cur_nonce`: 0.
  - `found_hash`, captured header, captured target: 0.
- FSM states: IDLE, ARM, REL, GO, WAIT, CHECK.
- IDLE:
  - `core_rst_n` = 0.
  - On `start`: clear `found`, `exhausted` and `timeout`; set `cur_nonce` = `nonce_start` and `busy` = 1; go to ARM.
- ARM: `core_rst_n` = 0 for one cycle; go to REL.
- REL: `core_rst_n` = 1 for one cycle, letting the core leave reset; go to GO.
- GO: `core_start` = 1 for exactly one cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - Remain until `core_done`, then go to CHECK.
  - If the watchdog counter reaches `WATCHDOG` first: set `timeout`, clear `busy`, go to IDLE.
- CHECK (single cycle), with `hv` = byte-reverse of `core_hash`:
  - If `hv` ≤ target: latch `found_nonce` = `cur_nonce`, `found_hash` = `hv`; set `found`, clear `busy`, go to IDLE.
  - Else if `cur_nonce` == `nonce_end`: set `exhausted`, clear `busy`, go to IDLE.
  - Else: `cur_nonce` += 1 modulo 2^32, go to ARM.
- Wrap: when `nonce_end` < `nonce_start` the sweep passes through FFFFFFFF to 0. Range 0..FFFFFFFF is the full 2^32 sweep.
- Comparison is 256-bit unsigned.
- `core_block` is driven combinationally from registers and is stable from ARM through CHECK.

## Timing
- Per nonce: 3 overhead cycles (ARM, REL, GO) + core latency + 1 cycle (CHECK).
- `found`, `exhausted` and `timeout` rise on the clock edge that leaves CHECK or WAIT; all three hold until the next accepted `start`.
- `abort` in any non-IDLE state:
  - go to IDLE on the next edge;
  - `busy` = 0 and `core_rst_n` = 0 on that edge;
  - status flags are not set.
- `abort` together with `start` in IDLE: `abort` wins, no scan begins.
- `load` together with `start` in IDLE: the new values are captured and used by that scan.
- A `core_done` already high in REL is a stale value and is ignored; it cannot occur after ARM, since ARM resets the core.
- `rst_n` asserted mid-scan: all outputs return to reset values immediately.

## Structure
- Package `miner_pkg` holds:
  - the state encoding localparams;
  - `HDR_W`=608, `BLK_W`=640;
  - a `bswap32` function and a 256-bit byte-reverse function.
- Sub-module `target_cmp`: combinational byte-reverse of `core_hash` plus the ≤ compare against target. Outputs `hv` and `hit`.
- The hash core is instantiated at the top level, not inside this block.

## Test plan
- Genesis header, target 00000000FFFF0000…0, range 7C2BAC1B..7C2BAC20:
  - `found` after the 3rd hash;
  - `found_nonce` = 7C2BAC1D;
  - `found_hash` = 000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f.
- Same header, range 0..3, same target: `exhausted` = 1, `found` = 0, exactly 4 `core_start` pulses.
- Target all-ones, range FFFFFFFE..FFFFFFFE: hit on the single nonce; `core_block[31:0]` = FEFFFFFF.
- Wrap check, using a core model reporting done after 5 cycles with no hit, range FFFFFFFF..00000001: the nonce sequence is FFFFFFFF, 0, 1, then `exhausted`.
- `abort` asserted during the 2nd WAIT: `busy` = 0 next cycle, `core_rst_n` = 0, no flags set. A following `start` rescans from `nonce_start`.
- Core model that never asserts `core_done`: `timeout` = 1 exactly `WATCHDOG` cycles after GO, `busy` = 0.

Source files
------------

// File: rtl/miner_pkg.sv
// -----------------------------------------------------------------------------
// miner_pkg
//   Shared definitions for the nonce scanner and its helpers.
//   - HDR_W / BLK_W : header template width (76 bytes) and core block width
//                     (80 bytes, header plus serialized nonce).
//   - state_t       : scanner FSM encoding, built from the ST_*_E localparams
//                     so the raw codes can be used by checkers on dbg_state.
//   - bswap32       : byte reverse of a 32-bit word.
//   - bswap256      : byte reverse of a 256-bit digest.
// -----------------------------------------------------------------------------
package miner_pkg;

    localparam int HDR_W = 608;
    localparam int BLK_W = 640;

    localparam logic [2:0] ST_IDLE_E  = 3'd0;
    localparam logic [2:0] ST_ARM_E   = 3'd1;
    localparam logic [2:0] ST_REL_E   = 3'd2;
    localparam logic [2:0] ST_GO_E    = 3'd3;
    localparam logic [2:0] ST_WAIT_E  = 3'd4;
    localparam logic [2:0] ST_CHECK_E = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = ST_IDLE_E,
        ST_ARM   = ST_ARM_E,
        ST_REL   = ST_REL_E,
        ST_GO    = ST_GO_E,
        ST_WAIT  = ST_WAIT_E,
        ST_CHECK = ST_CHECK_E
    } state_t;

    // Byte 0 (bits 7:0) moves to the top byte and so on.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = w[8*(3-i) +: 8];
        end
        return r;
    endfunction

    function automatic logic [255:0] bswap256(input logic [255:0] w);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = w[8*(31-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/target_cmp.sv
// -----------------------------------------------------------------------------
// target_cmp
//   Converts the hash core digest (core byte order) into its numeric / display
//   form and compares it against the 256-bit target.
//   Ports:
//     core_hash  in  256  digest as delivered by the core
//     target     in  256  numeric target
//     hv         out 256  byte-reversed digest (numeric value of the hash)
//     hit        out 1    hv <= target, unsigned
// -----------------------------------------------------------------------------
module target_cmp
    import miner_pkg::*;
(
    input  logic [255:0] core_hash,
    input  logic [255:0] target,
    output logic [255:0] hv,
    output logic         hit
);

    logic [255:0] w_hv;

    // The core emits the digest little-endian; the numeric value that the
    // target applies to is the byte-reversed word.
    assign w_hv = bswap256(core_hash);
    assign hv   = w_hv;
    assign hit  = (w_hv <= target);

endmodule

// File: rtl/nonce_scanner.sv
// -----------------------------------------------------------------------------
// nonce_scanner
//   Initiator for a single-shot double-SHA256 core. Holds a 76-byte header
//   template, sweeps the nonce over an inclusive (possibly wrapping) range and
//   issues one core transaction per nonce, reporting the first nonce whose
//   digest meets the target.
//
//   Core handshake: each transaction is ARM (core held in reset), REL (reset
//   released), GO (one-cycle core_start), then WAIT until core_done, which the
//   core holds high until core_rst_n falls. core_done is only looked at in
//   WAIT, so a stale level left from the previous nonce is never consumed.
//
//   Ports:
//     clk, rst_n               clock, asynchronous active-low reset
//     load                     capture header/target/range (IDLE only)
//     header_in  [607:0]       header template, first byte in the MSBs
//     target     [255:0]       numeric target (hit when hash <= target)
//     nonce_start, nonce_end   inclusive nonce range
//     start                    begin a scan (IDLE only)
//     abort                    level, stop the scan without flags
//     core_rst_n, core_start   core control (registered)
//     core_block [639:0]       {header, bswap32(cur_nonce)}
//     core_hash  [255:0]       core digest, core byte order
//     core_done                core completion, sticky
//     busy, found, exhausted, timeout   status
//     found_nonce, found_hash  result of the hit (hash in display order)
//     cur_nonce                nonce currently being hashed
//     dbg_state                FSM state code (miner_pkg ST_*_E)
// -----------------------------------------------------------------------------
module nonce_scanner
    import miner_pkg::*;
#(
    parameter int WATCHDOG = 511   // cycles allowed in WAIT; intended >= 300
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [HDR_W-1:0] header_in,
    input  logic [255:0]     target,
    input  logic [31:0]      nonce_start,
    input  logic [31:0]      nonce_end,
    input  logic             start,
    input  logic             abort,
    output logic             core_rst_n,
    output logic             core_start,
    output logic [BLK_W-1:0] core_block,
    input  logic [255:0]     core_hash,
    input  logic             core_done,
    output logic             busy,
    output logic             found,
    output logic [31:0]      found_nonce,
    output logic [255:0]     found_hash,
    output logic             exhausted,
    output logic             timeout,
    output logic [31:0]      cur_nonce,
    output logic [2:0]       dbg_state
);

    localparam int              WD_W    = $clog2(WATCHDOG + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG - 1);

    state_t           r_state;
    logic [HDR_W-1:0] r_header;
    logic [255:0]     r_target;
    logic [31:0]      r_nonce_start;
    logic [31:0]      r_nonce_end;
    logic [31:0]      r_cur_nonce;
    logic [31:0]      r_found_nonce;
    logic [255:0]     r_found_hash;
    logic             r_busy;
    logic             r_found;
    logic             r_exhausted;
    logic             r_timeout;
    logic             r_core_rst_n;
    logic             r_core_start;
    logic [WD_W-1:0]  r_wdog;

    logic [255:0]     w_hv;
    logic             w_hit;

    target_cmp u_target_cmp (
        .core_hash (core_hash),
        .target    (r_target),
        .hv        (w_hv),
        .hit       (w_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_header      <= '0;
            r_target      <= '0;
            r_nonce_start <= '0;
            r_nonce_end   <= '0;
            r_cur_nonce   <= '0;
            r_found_nonce <= '0;
            r_found_hash  <= '0;
            r_busy        <= 1'b0;
            r_found       <= 1'b0;
            r_exhausted   <= 1'b0;
            r_timeout     <= 1'b0;
            r_core_rst_n  <= 1'b0;
            r_core_start  <= 1'b0;
            r_wdog        <= '0;
        end else begin
            // core_start is a single-cycle pulse: only the REL->GO transition
            // raises it.
            r_core_start <= 1'b0;

            if (r_state == ST_IDLE) begin
                r_core_rst_n <= 1'b0;
                if (load) begin
                    r_header      <= header_in;
                    r_target      <= target;
                    r_nonce_start <= nonce_start;
                    r_nonce_end   <= nonce_end;
                end
                // abort beats start; a simultaneous load feeds this scan, so
                // the first nonce bypasses the capture register.
                if (start && !abort) begin
                    r_found     <= 1'b0;
                    r_exhausted <= 1'b0;
                    r_timeout   <= 1'b0;
                    r_cur_nonce <= load ? nonce_start : r_nonce_start;
                    r_busy      <= 1'b1;
                    r_state     <= ST_ARM;
                end
            end else if (abort) begin
                r_busy       <= 1'b0;
                r_core_rst_n <= 1'b0;
                r_state      <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_ARM: begin
                        r_core_rst_n <= 1'b1;
                        r_state      <= ST_REL;
                    end
                    ST_REL: begin
                        r_core_start <= 1'b1;
                        r_state      <= ST_GO;
                    end
                    ST_GO: begin
                        r_wdog  <= '0;
                        r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        // The counter holds the number of WAIT cycles already
                        // spent; the WATCHDOG-th WAIT edge without done fires.
                        if (core_done) begin
                            r_state <= ST_CHECK;
                        end else if (r_wdog == WD_LAST) begin
                            r_timeout    <= 1'b1;
                            r_busy       <= 1'b0;
                            r_core_rst_n <= 1'b0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_wdog <= r_wdog + WD_W'(1);
                        end
                    end
                    ST_CHECK: begin
                        r_core_rst_n <= 1'b0;
                        if (w_hit) begin
                            r_found_nonce <= r_cur_nonce;
                            r_found_hash  <= w_hv;
                            r_found       <= 1'b1;
                            r_busy        <= 1'b0;
                            r_state       <= ST_IDLE;
                        end else if (r_cur_nonce == r_nonce_end) begin
                            r_exhausted <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            // Natural 32-bit wrap gives the FFFFFFFF -> 0 sweep.
                            r_cur_nonce <= r_cur_nonce + 32'd1;
                            r_state     <= ST_ARM;
                        end
                    end
                    default: begin
                        r_busy       <= 1'b0;
                        r_core_rst_n <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign core_rst_n  = r_core_rst_n;
    assign core_start  = r_core_start;
    assign core_block  = {r_header, bswap32(r_cur_nonce)};
    assign busy        = r_busy;
    assign found       = r_found;
    assign found_nonce = r_found_nonce;
    assign found_hash  = r_found_hash;
    assign exhausted   = r_exhausted;
    assign timeout     = r_timeout;
    assign cur_nonce   = r_cur_nonce;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_nonce_scanner.sv
// -----------------------------------------------------------------------------
// tb_nonce_scanner
//   Bench for nonce_scanner with a behavioural single-shot hash core. The core
//   model returns the genesis digest for one selectable nonce and all-ones for
//   every other nonce; core_done stays high until core_rst_n falls.
// -----------------------------------------------------------------------------
module tb_nonce_scanner;

    localparam int WD = 511;

    localparam logic [607:0] GEN_HDR = 608'h0100000000000000000000000000000000000000000000000000000000000000000000003ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a29ab5f49ffff001d;
    localparam logic [255:0] GEN_DISP = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
    localparam logic [255:0] TGT_GEN  = 256'h00000000ffff0000000000000000000000000000000000000000000000000000;
    localparam logic [255:0] ONES     = {256{1'b1}};

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT signals
    logic         load = 1'b0;
    logic [607:0] header_in = '0;
    logic [255:0] target = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         core_rst_n;
    logic         core_start;
    logic [639:0] core_block;
    logic [255:0] core_hash = '0;
    logic         core_done = 1'b0;
    logic         busy;
    logic         found;
    logic [31:0]  found_nonce;
    logic [255:0] found_hash;
    logic         exhausted;
    logic         timeout;
    logic [31:0]  cur_nonce;
    logic [2:0]   dbg_state;

    nonce_scanner #(.WATCHDOG(WD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .header_in   (header_in),
        .target      (target),
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .start       (start),
        .abort       (abort),
        .core_rst_n  (core_rst_n),
        .core_start  (core_start),
        .core_block  (core_block),
        .core_hash   (core_hash),
        .core_done   (core_done),
        .busy        (busy),
        .found       (found),
        .found_nonce (found_nonce),
        .found_hash  (found_hash),
        .exhausted   (exhausted),
        .timeout     (timeout),
        .cur_nonce   (cur_nonce),
        .dbg_state   (dbg_state)
    );

    // bookkeeping
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] tb_bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [255:0] tb_bswap256(input logic [255:0] w);
        logic [255:0] r;
        for (int i = 0; i < 256; i += 8) r[255-i -: 8] = w[i +: 8];
        return r;
    endfunction

    // hash core model
    bit          use_hit = 1'b0;
    logic [31:0] hit_nonce = '0;
    bit          never_done = 1'b0;
    int          fixed_lat = 0;
    bit          m_run = 1'b0;
    int          m_cnt = 0;
    int          m_lat = 2;
    logic [31:0] m_nonce = '0;

    function automatic logic [255:0] model_hash(input logic [31:0] n);
        if (use_hit && n == hit_nonce) return tb_bswap256(GEN_DISP);
        return ONES;
    endfunction

    // m_lat is the number of WAIT cycles the scanner will see before done.
    always @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            m_run     <= 1'b0;
            m_cnt     <= 0;
            core_done <= 1'b0;
        end else if (core_start) begin
            m_run   <= 1'b1;
            m_cnt   <= 1;
            m_lat   <= (fixed_lat != 0) ? fixed_lat : int'($urandom_range(2, 12));
            m_nonce <= tb_bswap32(core_block[31:0]);
        end else if (m_run && !never_done) begin
            if (m_cnt >= m_lat - 1) begin
                core_done <= 1'b1;
                core_hash <= model_hash(m_nonce);
                m_run     <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // scoreboard: expected nonce per core_start
    logic [31:0]  exp_q[$];
    logic [607:0] exp_hdr = GEN_HDR;
    int           n_starts = 0;
    int           cyc = 0;
    int           prev_cyc = 0;
    bit           prev_valid = 1'b0;
    logic [31:0]  mon_e;

    always @(negedge clk) begin
        cyc++;
        if (rst_n && core_start) begin
            n_starts++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_start: got nonce %0h expected no transaction", cur_nonce);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_nonce", 640'(core_block[31:0]), 640'(tb_bswap32(mon_e)));
                check("sb_header", 640'(core_block[639:32]), 640'(exp_hdr));
            end
            if (prev_valid && fixed_lat != 0)
                check("sb_period", 640'(cyc - prev_cyc), 640'(3 + fixed_lat + 1));
            prev_cyc   = cyc;
            prev_valid = 1'b1;
        end
    end

    // driver tasks
    task automatic do_load(input logic [255:0] tgt, input logic [31:0] s, input logic [31:0] e);
        header_in = GEN_HDR; target = tgt; nonce_start = s; nonce_end = e;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Expected nonce order, stopping at the first hit or at the end nonce.
    task automatic build_exp(input logic [31:0] s, input logic [31:0] e,
                             input logic [255:0] tgt, output logic [31:0] last);
        logic [31:0] n;
        n = s;
        last = s;
        exp_q.delete();
        for (int k = 0; k < 64; k++) begin
            exp_q.push_back(n);
            last = n;
            if (tb_bswap256(model_hash(n)) <= tgt) break;
            if (n == e) break;
            n = n + 32'd1;
        end
        prev_valid = 1'b0;
        n_starts = 0;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!busy) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: got busy after 2000 cycles expected idle", name);
    endtask

    typedef struct {
        logic [31:0]  s;
        logic [31:0]  e;
        logic [255:0] tgt;
        bit           hit_en;
        logic [31:0]  hit_n;
        int           lat;
        bit           exp_found;
        bit           exp_exh;
        logic [31:0]  exp_fn;
        logic [255:0] exp_fh;
        int           exp_starts;
    } vec_t;

    vec_t tv[6];

    initial begin
        logic [31:0] last;
        int          n;

        tv[0] = '{32'h7C2BAC1B, 32'h7C2BAC20, TGT_GEN, 1'b1, 32'h7C2BAC1D, 0, 1'b1, 1'b0, 32'h7C2BAC1D, GEN_DISP, 3};
        tv[1] = '{32'h00000000, 32'h00000003, TGT_GEN, 1'b1, 32'h7C2BAC1D, 0, 1'b0, 1'b1, 32'h0, 256'h0, 4};
        tv[2] = '{32'hFFFFFFFE, 32'hFFFFFFFE, ONES, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'hFFFFFFFE, ONES, 1};
        tv[3] = '{32'hFFFFFFFF, 32'h00000001, TGT_GEN, 1'b0, 32'h0, 5, 1'b0, 1'b1, 32'h0, 256'h0, 3};
        tv[4] = '{32'h00000005, 32'h00000005, GEN_DISP, 1'b1, 32'h5, 0, 1'b1, 1'b0, 32'h5, GEN_DISP, 1};
        tv[5] = '{32'h00000005, 32'h00000007, GEN_DISP - 256'd1, 1'b1, 32'h6, 4, 1'b0, 1'b1, 32'h0, 256'h0, 3};

        // reset
        repeat (3) @(negedge clk);
        check("rst_ctrl", 640'({core_rst_n, core_start, busy, found, exhausted, timeout}), 640'(0));
        check("rst_nonces", 640'({found_nonce, cur_nonce}), 640'(0));
        check("rst_hash", 640'(found_hash), 640'(0));
        check("rst_block", core_block, 640'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // table-driven scans
        for (int i = 0; i < 6; i++) begin
            use_hit   = tv[i].hit_en;
            hit_nonce = tv[i].hit_n;
            fixed_lat = tv[i].lat;
            do_load(tv[i].tgt, tv[i].s, tv[i].e);
            build_exp(tv[i].s, tv[i].e, tv[i].tgt, last);
            pulse_start();
            check("v_start_flags", 640'({busy, found, exhausted, timeout}), 640'(4'b1000));
            wait_idle("v_done");
            check("v_found", 640'(found), 640'(tv[i].exp_found));
            check("v_exhausted", 640'(exhausted), 640'(tv[i].exp_exh));
            check("v_timeout", 640'(timeout), 640'(0));
            check("v_starts", 640'(n_starts), 640'(tv[i].exp_starts));
            check("v_queue_left", 640'(exp_q.size()), 640'(0));
            check("v_cur_nonce", 640'(cur_nonce), 640'(last));
            check("v_block_nonce", 640'(core_block[31:0]), 640'(tb_bswap32(last)));
            if (tv[i].exp_found) begin
                check("v_found_nonce", 640'(found_nonce), 640'(tv[i].exp_fn));
                check("v_found_hash", 640'(found_hash), 640'(tv[i].exp_fh));
            end
        end
        // single-nonce range at the top of the space serializes as FEFFFFFF
        do_load(ONES, 32'hFFFFFFFE, 32'hFFFFFFFE);
        build_exp(32'hFFFFFFFE, 32'hFFFFFFFE, ONES, last);
        pulse_start();
        wait_idle("top_done");
        check("top_block_lsw", 640'(core_block[31:0]), 640'(32'hFEFFFFFF));

        // abort during the 2nd WAIT, then rescan from nonce_start
        use_hit = 1'b0;
        fixed_lat = 8;
        do_load(TGT_GEN, 32'd0, 32'd10);
        build_exp(32'd0, 32'd10, TGT_GEN, last);
        pulse_start();
        n = 0;
        for (int k = 0; k < 200 && n < 2; k++) begin
            @(negedge clk);
            if (core_start) n++;
        end
        check("ab_second_go", 640'(n), 640'(2));
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_busy_rst", 640'({busy, core_rst_n}), 640'(0));
        check("ab_flags", 640'({found, exhausted, timeout}), 640'(0));
        exp_q.delete();
        n = n_starts;
        repeat (20) @(negedge clk);
        check("ab_quiet", 640'(n_starts), 640'(n));
        build_exp(32'd0, 32'd10, TGT_GEN, last);
        pulse_start();
        wait_idle("ab_rescan");
        check("ab_rescan_exh", 640'({found, exhausted}), 640'(2'b01));
        check("ab_rescan_starts", 640'(n_starts), 640'(11));

        // abort together with start in IDLE: nothing begins
        fixed_lat = 0;
        n = n_starts;
        abort = 1'b1;
        pulse_start();
        abort = 1'b0;
        check("abst_busy", 640'(busy), 640'(0));
        repeat (6) @(negedge clk);
        check("abst_no_go", 640'(n_starts), 640'(n));

        // load together with start: new range is used immediately
        header_in = GEN_HDR; target = TGT_GEN; nonce_start = 32'd20; nonce_end = 32'd21;
        build_exp(32'd20, 32'd21, TGT_GEN, last);
        load = 1'b1;
        pulse_start();
        load = 1'b0;
        wait_idle("ls_done");
        check("ls_exhausted", 640'({found, exhausted}), 640'(2'b01));
        check("ls_cur_nonce", 640'(cur_nonce), 640'(32'd21));

        // watchdog: core never completes; timeout rises WD edges after GO
        never_done = 1'b1;
        do_load(TGT_GEN, 32'd0, 32'd5);
        exp_q.delete();
        exp_q.push_back(32'd0);
        prev_valid = 1'b0;
        pulse_start();
        n = 0;
        for (int k = 0; k < 10 && !core_start; k++) @(negedge clk);
        check("wd_go_seen", 640'(core_start), 640'(1));
        for (int k = 0; k < WD + 50; k++) begin
            @(negedge clk);
            n++;
            if (timeout) break;
        end
        // n counts sampled cycles after the GO cycle; the first WAIT cycle is 1
        check("wd_cycles", 640'(n), 640'(WD + 1));
        check("wd_flags", 640'({busy, found, exhausted, timeout}), 640'(4'b0001));
        check("wd_core_rst", 640'(core_rst_n), 640'(0));
        never_done = 1'b0;

        // asynchronous reset mid-scan
        do_load(TGT_GEN, 32'd0, 32'd20);
        build_exp(32'd0, 32'd20, TGT_GEN, last);
        pulse_start();
        repeat (7) @(negedge clk);
        check("mr_busy_before", 640'(busy), 640'(1));
        rst_n = 1'b0;
        #1;
        check("mr_ctrl", 640'({core_rst_n, core_start, busy, found, exhausted, timeout}), 640'(0));
        check("mr_nonces", 640'({found_nonce, cur_nonce}), 640'(0));
        check("mr_hash_block", 640'(found_hash) | core_block, 640'(0));
        check("mr_state", 640'(dbg_state), 640'(0));
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no end of test expected finish before 2000000");
        $fatal(1, "time limit");
    end

endmodule
